// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer.
//   state_t          : sequencer states IDLE -> CLEAR -> FEED -> DRAIN -> DONE
//   DEF_ARRAY_SIZE   : default array dimension N
//   DEF_DATA_WIDTH   : default element width
//   lane_lo()        : low bit index of lane/element k in a packed N*DW vector
package systolic_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host load bus for the systolic sequencer.
//   valid : host load request
//   ready : load accepted when valid & ready
//   sel   : 0 = A buffer row, 1 = B buffer column
//   idx   : row (A) or column (B) index
//   data  : N elements, element k at bits [k*DW +: DW]
// master = host side, slave = sequencer side.
interface systolic_ctrl_if
  import systolic_pkg::*;
#(
  parameter int N  = DEF_ARRAY_SIZE,
  parameter int DW = DEF_DATA_WIDTH
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          valid;
  logic          ready;
  logic          sel;
  logic [IW-1:0] idx;
  logic [N*DW-1:0] data;

  modport master (output valid, output sel, output idx, output data, input ready);
  modport slave  (input valid, input sel, input idx, input data, output ready);
endinterface

// File: rtl/skew_feeder.sv
// One N x N operand buffer plus the diagonal skew read-out.
// Vector v (row of A, or column of B) is written whole through the load port.
// Read-out is registered: when rd_en is high at a clock edge, lane i of
// 'lanes' becomes element (rd_t - i) of vector i, or 0 when that index falls
// outside 0..N-1; when rd_en is low the lanes clear to 0.
//   clk, reset        : clock, asynchronous active-low reset (clears buffer)
//   wr_en/wr_idx/wr_data : vector write
//   rd_en, rd_t       : skew beat to present on the next cycle
//   lanes             : registered N-lane skewed output
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = DEF_ARRAY_SIZE,
  parameter int DW = DEF_DATA_WIDTH,
  parameter int IW = 2,
  parameter int TW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [N*DW-1:0] wr_data,
  input  logic            rd_en,
  input  logic [TW-1:0]   rd_t,
  output logic [N*DW-1:0] lanes
);

  logic [N*DW-1:0] rows [N];
  logic [N*DW-1:0] lanes_reg;
  logic [N*DW-1:0] lanes_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      logic [N*DW-1:0] row_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          row_reg <= '0;
        end else if (wr_en && (wr_idx == IW'(gi))) begin
          row_reg <= wr_data;
        end
      end

      assign rows[gi] = row_reg;
    end
  endgenerate

  // Lane i lags lane i-1 by one beat, which produces the diagonal wavefront.
  always_comb begin
    int k;
    lanes_next = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(rd_t) - i;
      if (rd_en && (k >= 0) && (k < N)) begin
        lanes_next[lane_lo(i, DW) +: DW] = rows[i][lane_lo(k, DW) +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes_reg <= '0;
    end else begin
      lanes_reg <= lanes_next;
    end
  end

  assign lanes = lanes_reg;

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N systolic array.
// Buffers A (rows) and B (columns) from the host, and on start clears the
// array for one cycle, feeds the skewed wavefront for 2N-1 beats, waits
// DRAIN_CYCLES, snapshots arr_out_bot into result and pulses done.
//   clk, reset   : clock, asynchronous active-low reset
//   ld           : host load bus (slave side), accepted only in IDLE
//   start, abort : run control (abort wins over start, no effect in IDLE)
//   busy, done   : status; done is a one-cycle pulse with result valid
//   result       : out_bot snapshot, held until the next done
//   arr_reset    : active-high clear to the array
//   arr_in_left  : lane i -> array row i
//   arr_in_top   : lane j -> array column j
//   arr_out_bot  : array bottom output
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE   = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  systolic_ctrl_if.slave                 ld,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] result,
  output logic                           arr_reset,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_in_left,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_in_top,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_out_bot
);

  localparam int N   = ARRAY_SIZE;
  localparam int DW  = DATA_WIDTH;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int TW  = $clog2(2 * N);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [TW-1:0]    t_reg, t_next;
  logic [DCW-1:0]   drain_reg, drain_next;
  logic             arr_reset_reg, arr_reset_next;
  logic [N*DW-1:0]  result_reg;
  logic             abort_run;
  logic             load_fire;
  logic             capture;

  assign abort_run = abort && (state_reg != IDLE);
  assign load_fire = ld.valid && ld.ready;
  // Snapshot on the final drain cycle unless that same cycle is aborted.
  assign capture   = (state_reg == DRAIN) && (drain_reg == D_LAST) && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      t_reg         <= '0;
      drain_reg     <= '0;
      arr_reset_reg <= 1'b1;
      result_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      t_reg         <= t_next;
      drain_reg     <= drain_next;
      arr_reset_reg <= arr_reset_next;
      if (capture) begin
        result_reg <= arr_out_bot;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    drain_next = drain_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = FEED;
        t_next     = '0;
      end
      FEED: begin
        if (t_reg == T_LAST) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          t_next = t_reg + TW'(1);
        end
      end
      DRAIN: begin
        if (drain_reg == D_LAST) begin
          state_next = DONE;
        end else begin
          drain_next = drain_reg + DCW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort_run) begin
      state_next = IDLE;
    end
    // Array clear is registered so it is already high while in CLEAR and on
    // the first IDLE cycle after an abort.
    arr_reset_next = (state_next == CLEAR) || abort_run;
  end

  // The feeders register their lanes, so they are steered by the next beat.
  skew_feeder #(.N(N), .DW(DW), .IW(IW), .TW(TW)) u_feed_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_fire && !ld.sel),
    .wr_idx  (ld.idx),
    .wr_data (ld.data),
    .rd_en   (state_next == FEED),
    .rd_t    (t_next),
    .lanes   (arr_in_left)
  );

  skew_feeder #(.N(N), .DW(DW), .IW(IW), .TW(TW)) u_feed_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_fire && ld.sel),
    .wr_idx  (ld.idx),
    .wr_data (ld.data),
    .rd_en   (state_next == FEED),
    .rd_t    (t_next),
    .lanes   (arr_in_top)
  );

  assign ld.ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign result    = result_reg;
  assign arr_reset = arr_reset_reg;

endmodule
